// File: rtl/mips_debug_controller.sv
// Debug sequencer between the UART and the MIPS pipeline. It runs or single-steps
// the pipeline, then streams PC, the register file and data memory out MSB first.
//
// state | meaning
// IDLE  | waiting for a command byte
// RUN   | pipeline free-running until halt
// STEP  | pipeline advanced for one clock
// LOAD  | read data settling for the current dump item
// SEND  | four bytes of the current item going out to TX
module mips_debug_controller #(
  parameter int NB              = 32,
  parameter int NB_REG          = 5,
  parameter int TAM_DATA_MEMORY = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_cmd,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  input  logic [NB-1:0]     i_mips_pc,
  input  logic [NB-1:0]     i_mips_register_data,
  input  logic [NB-1:0]     i_mips_data_memory,
  input  logic              i_mips_halt,
  output logic              o_mips_step,
  output logic [NB_REG-1:0] o_debug_register_number,
  output logic [NB-1:0]     o_debug_address,
  output logic              o_busy
);

  localparam int N_ITEMS = 33 + TAM_DATA_MEMORY;
  localparam int ITEM_W  = $clog2(N_ITEMS);
  localparam logic [ITEM_W-1:0] ITEM_LAST = ITEM_W'(N_ITEMS - 1);
  localparam logic [ITEM_W-1:0] ITEM_MEM0 = ITEM_W'(33);
  localparam logic [ITEM_W-1:0] ITEM_ONE  = ITEM_W'(1);

  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_READ = 8'h52;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_LOAD,
    ST_SEND
  } state_t;

  state_t            state;
  logic [ITEM_W-1:0] item;
  logic [1:0]        byte_cnt;
  logic [NB-1:0]     shift;
  logic [NB-1:0]     load_word;
  logic              is_reg;
  logic              is_mem;

  assign is_reg = (item != '0) && (item < ITEM_MEM0);
  assign is_mem = (item >= ITEM_MEM0);

  always_comb begin
    load_word = i_mips_data_memory;
    if (item == '0)
      load_word = i_mips_pc;
    else if (is_reg)
      load_word = i_mips_register_data;
  end

  assign o_cmd_ready             = (state == ST_IDLE);
  assign o_busy                  = (state != ST_IDLE);
  assign o_mips_step             = (state == ST_RUN) || (state == ST_STEP);
  assign o_tx_valid              = (state == ST_SEND);
  assign o_tx_data               = shift[NB-1 -: 8];
  assign o_debug_register_number = is_reg ? NB_REG'(item - ITEM_ONE) : '0;
  // word index scaled to a byte address
  assign o_debug_address         = is_mem ? NB'({item - ITEM_MEM0, 2'b00}) : '0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      item     <= '0;
      byte_cnt <= '0;
      shift    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            item <= '0;
            case (i_cmd)
              CMD_RUN:  state <= i_mips_halt ? ST_LOAD : ST_RUN;
              CMD_STEP: state <= i_mips_halt ? ST_LOAD : ST_STEP;
              CMD_READ: state <= ST_LOAD;
              default:  state <= ST_IDLE;
            endcase
          end
        end
        ST_RUN: begin
          if (i_mips_halt)
            state <= ST_LOAD;
        end
        ST_STEP: state <= ST_LOAD;
        ST_LOAD: begin
          shift    <= load_word;
          byte_cnt <= '0;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          if (i_tx_ready) begin
            shift    <= {shift[NB-9:0], 8'h00};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (item == ITEM_LAST) begin
                item  <= '0;
                state <= ST_IDLE;
              end else begin
                item  <= item + ITEM_ONE;
                state <= ST_LOAD;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_debug_controller.sv
// Directed bench for mips_debug_controller: a small pipeline model feeds PC,
// registers and memory, and a byte queue holds the dump each command should produce.
module tb_mips_debug_controller;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [7:0]  i_cmd;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic [31:0] i_mips_pc;
  logic [31:0] i_mips_register_data;
  logic [31:0] i_mips_data_memory;
  logic        i_mips_halt;
  logic        o_mips_step;
  logic [4:0]  o_debug_register_number;
  logic [31:0] o_debug_address;
  logic        o_busy;

  mips_debug_controller dut (
    .i_clk                   (i_clk),
    .i_reset                 (i_reset),
    .i_cmd                   (i_cmd),
    .i_cmd_valid             (i_cmd_valid),
    .o_cmd_ready             (o_cmd_ready),
    .o_tx_data               (o_tx_data),
    .o_tx_valid              (o_tx_valid),
    .i_tx_ready              (i_tx_ready),
    .i_mips_pc               (i_mips_pc),
    .i_mips_register_data    (i_mips_register_data),
    .i_mips_data_memory      (i_mips_data_memory),
    .i_mips_halt             (i_mips_halt),
    .o_mips_step             (o_mips_step),
    .o_debug_register_number (o_debug_register_number),
    .o_debug_address         (o_debug_address),
    .o_busy                  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  logic [31:0] regs [32];
  logic [31:0] mem  [16];
  logic [31:0] pc;

  assign i_mips_pc            = pc;
  assign i_mips_register_data = regs[o_debug_register_number];
  assign i_mips_data_memory   = mem[o_debug_address[5:2]];

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  rx_log [256];
  int          rx_cnt;
  int          step_cnt;
  int          busy_cnt;
  logic        last_ready;
  logic        last_busy;
  logic        hold_pending;
  logic [7:0]  hold_byte;
  logic        bp_mode;
  logic        ok;
  logic [7:0]  exp_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
  endtask

  task automatic push_dump();
    push_word(pc);
    for (int i = 0; i < 32; i++) push_word(regs[i]);
    for (int i = 0; i < 16; i++) push_word(mem[i]);
  endtask

  // One clock: sample everything on the falling edge, then advance past the rising edge.
  task automatic tick();
    @(negedge i_clk);
    last_ready = o_cmd_ready;
    last_busy  = o_busy;
    if (o_mips_step) step_cnt++;
    if (o_busy) busy_cnt++;
    if (hold_pending) begin
      check("hold_valid", {31'b0, o_tx_valid}, 32'd1);
      check("hold_data", {24'b0, o_tx_data}, {24'b0, hold_byte});
    end
    hold_pending = 1'b0;
    if (o_tx_valid) begin
      if (i_tx_ready) begin
        if (exp_q.size() == 0) begin
          check("tx_unexpected", {31'b0, o_tx_valid}, 32'd0);
        end else begin
          exp_b = exp_q.pop_front();
          check("tx_byte", {24'b0, o_tx_data}, {24'b0, exp_b});
        end
        if (rx_cnt < 256) rx_log[rx_cnt] = o_tx_data;
        if (rx_cnt >= 24 && rx_cnt <= 27)
          check("dbg_reg5", {27'b0, o_debug_register_number}, 32'd5);
        if (rx_cnt >= 140 && rx_cnt <= 143)
          check("dbg_addr8", o_debug_address, 32'd8);
        rx_cnt++;
      end else begin
        hold_pending = 1'b1;
        hold_byte    = o_tx_data;
      end
    end
    @(posedge i_clk);
    #1;
    if (bp_mode) i_tx_ready = ~i_tx_ready;
  endtask

  task automatic send_cmd(input logic [7:0] c, input int budget);
    i_cmd       = c;
    i_cmd_valid = 1'b1;
    ok          = 1'b0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (last_ready) begin
        ok = 1'b1;
        break;
      end
    end
    i_cmd_valid = 1'b0;
    check("cmd_accept", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (!last_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", {31'b0, ok}, 32'd1);
  endtask

  task automatic start_counts();
    rx_cnt   = 0;
    step_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'b0, o_tx_valid}, 32'd0);
    check({tag, "_data"}, {24'b0, o_tx_data}, 32'd0);
    check({tag, "_step"}, {31'b0, o_mips_step}, 32'd0);
    check({tag, "_regnum"}, {27'b0, o_debug_register_number}, 32'd0);
    check({tag, "_addr"}, o_debug_address, 32'd0);
    check({tag, "_busy"}, {31'b0, o_busy}, 32'd0);
    check({tag, "_ready"}, {31'b0, o_cmd_ready}, 32'd1);
  endtask

  task automatic check_first_word(input string tag);
    check({tag, "_b0"}, {24'b0, rx_log[0]}, 32'h00);
    check({tag, "_b1"}, {24'b0, rx_log[1]}, 32'h00);
    check({tag, "_b2"}, {24'b0, rx_log[2]}, 32'h00);
    check({tag, "_b3"}, {24'b0, rx_log[3]}, 32'h1C);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 | (i * 32'h0001_0203);
    for (int i = 0; i < 16; i++) mem[i] = 32'h5000_0000 + i * 32'h0000_0111;
    regs[5] = 32'hDEAD_BEEF;
    mem[2]  = 32'h1234_5678;
    pc      = 32'h0000_001C;

    i_reset      = 1'b0;
    i_cmd        = 8'h00;
    i_cmd_valid  = 1'b0;
    i_tx_ready   = 1'b1;
    i_mips_halt  = 1'b0;
    bp_mode      = 1'b0;
    hold_pending = 1'b0;
    hold_byte    = 8'h00;
    last_ready   = 1'b0;
    last_busy    = 1'b0;
    exp_b        = 8'h00;
    ok           = 1'b0;
    start_counts();

    // asynchronous reset between clock edges
    #2 i_reset = 1'b1;
    #1 check_reset_outputs("rst");
    @(posedge i_clk);
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    repeat (3) tick();
    check("post_rst_busy", {31'b0, o_busy}, 32'd0);
    check("post_rst_steps", step_cnt, 32'd0);

    // invalid command consumed, nothing happens
    start_counts();
    send_cmd(8'h41, 10);
    repeat (4) tick();
    check("inv_busy", busy_cnt, 32'd0);
    check("inv_steps", step_cnt, 32'd0);
    check("inv_ready", {31'b0, o_cmd_ready}, 32'd1);

    // single step
    start_counts();
    send_cmd(8'h53, 10);
    push_dump();
    wait_idle(400);
    check("s_steps", step_cnt, 32'd1);
    check("s_busy_cycles", busy_cnt, 32'd246);
    check("s_bytes", rx_cnt, 32'd196);
    check("s_q_empty", exp_q.size(), 32'd0);
    check_first_word("s");

    // free run, halt raised during the 10th RUN cycle
    start_counts();
    send_cmd(8'h43, 10);
    repeat (9) tick();
    i_mips_halt = 1'b1;
    push_dump();
    wait_idle(400);
    i_mips_halt = 1'b0;
    check("c_steps", step_cnt, 32'd10);
    check("c_busy_cycles", busy_cnt, 32'd255);
    check("c_bytes", rx_cnt, 32'd196);
    check("c_q_empty", exp_q.size(), 32'd0);

    // run requested while already halted
    start_counts();
    i_mips_halt = 1'b1;
    send_cmd(8'h43, 10);
    push_dump();
    wait_idle(400);
    i_mips_halt = 1'b0;
    check("ch_steps", step_cnt, 32'd0);
    check("ch_busy_cycles", busy_cnt, 32'd245);
    check("ch_bytes", rx_cnt, 32'd196);

    // backpressure with ready alternating 1,0
    start_counts();
    bp_mode    = 1'b1;
    i_tx_ready = 1'b1;
    send_cmd(8'h52, 10);
    push_dump();
    wait_idle(1200);
    bp_mode    = 1'b0;
    i_tx_ready = 1'b1;
    check("bp_steps", step_cnt, 32'd0);
    check("bp_bytes", rx_cnt, 32'd196);
    check("bp_q_empty", exp_q.size(), 32'd0);
    check("bp_r5", {rx_log[24], rx_log[25], rx_log[26], rx_log[27]}, 32'hDEAD_BEEF);
    check("bp_m2", {rx_log[140], rx_log[141], rx_log[142], rx_log[143]}, 32'h1234_5678);

    // 'S' offered during a dump waits for IDLE
    start_counts();
    send_cmd(8'h52, 10);
    push_dump();
    repeat (5) tick();
    send_cmd(8'h53, 400);
    check("busy_s_after_dump", rx_cnt, 32'd196);
    check("busy_s_q_empty", exp_q.size(), 32'd0);
    check("busy_s_no_step_yet", step_cnt, 32'd0);
    start_counts();
    push_dump();
    wait_idle(400);
    check("busy_s_steps", step_cnt, 32'd1);
    check("busy_s_bytes", rx_cnt, 32'd196);

    // reset in the middle of a dump
    start_counts();
    send_cmd(8'h52, 10);
    push_dump();
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (rx_cnt >= 50) begin
        ok = 1'b1;
        break;
      end
    end
    check("mid_reach50", {31'b0, ok}, 32'd1);
    #2 i_reset = 1'b1;
    #1 check_reset_outputs("mid_rst");
    exp_q.delete();
    hold_pending = 1'b0;
    #3 i_reset = 1'b0;
    repeat (2) tick();
    check("mid_quiet", {31'b0, o_tx_valid}, 32'd0);
    start_counts();
    send_cmd(8'h52, 10);
    push_dump();
    wait_idle(400);
    check("mid_bytes", rx_cnt, 32'd196);
    check("mid_q_empty", exp_q.size(), 32'd0);
    check_first_word("mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_debug_controller.md
# mips_debug_controller

Sequencer that owns the MIPS pipeline's `i_step`, `i_debug_mips_register_number` and `i_debug_address` inputs, and consumes its `o_mips_pc`, `o_mips_register_data` and `o_mips_data_memory` outputs. It takes single-byte commands from the UART RX side and either free-runs the pipeline until halt or advances it one clock. After either, it serializes a full state dump (PC, 32 registers, data memory) as bytes to the UART TX side. It sits between the UART and `PIPELINE` in the top level.

## Interface
- `NB`, 32, datapath word width
- `NB_REG`, 5, register-number width
- `TAM_DATA_MEMORY`, 16, data-memory words dumped
- `i_clk`  in  1  clock
- `i_reset`  in  1  asynchronous, active-high reset
- `i_cmd`  in  8  command byte from UART RX
- `i_cmd_valid`  in  1  command byte present
- `o_cmd_ready`  out  1  controller can accept a command
- `o_tx_data`  out  8  byte to UART TX
- `o_tx_valid`  out  1  `o_tx_data` valid
- `i_tx_ready`  in  1  UART TX accepts the byte
- `i_mips_pc`  in  NB  pipeline PC
- `i_mips_register_data`  in  NB  register-file read data
- `i_mips_data_memory`  in  NB  data-memory read data
- `i_mips_halt`  in  1  program finished (HALT reached write-back)
- `o_mips_step`  out  1  pipeline clock enable
- `o_debug_register_number`  out  NB_REG  register selected for readout
- `o_debug_address`  out  NB  data-memory byte address for readout
- `o_busy`  out  1  controller not in IDLE

## Operation
- States: IDLE, RUN, STEP, LOAD, SEND.
- All outputs decode from registers only. There are no combinational input-to-output paths except through `o_cmd_ready`, which equals `state==IDLE`.
- **Command acceptance:** a command is accepted on an edge where `i_cmd_valid` and `o_cmd_ready` are both high.
  - 0x43 'C' → RUN.
  - 0x53 'S' → STEP.
  - 0x52 'R' → LOAD, dump only.
  - Any other byte is consumed and ignored; the controller stays in IDLE.
- **Halt already high:** if `i_mips_halt` is high when 'C' or 'S' is accepted, the controller goes directly to LOAD and issues no step.
- **RUN:** `o_mips_step`=1 every cycle. On an edge where `i_mips_halt`=1, the controller goes to LOAD.
- **STEP:** `o_mips_step`=1 for exactly this one cycle, then LOAD.
- **Item counter:** 0..32+TAM_DATA_MEMORY.
  - Item 0 = PC.
  - Items 1..32 = register item-1. `o_debug_register_number` = item-1.
  - Items 33.. = memory word item-33. `o_debug_address` = (item-33)<<2.
  - When the current item is not of that type, the corresponding debug output is 0.
- **LOAD:** lasts one cycle to let read data settle. At its closing edge, the selected input word is latched into a 32-bit shift register, the byte counter is cleared, and the state goes to SEND.
- **SEND:**
  - `o_tx_valid`=1 and `o_tx_data`=shift[NB-1:NB-8], so bytes go out MSB first.
  - On each handshake edge (`o_tx_valid` & `i_tx_ready`), the shift register shifts left by 8 and the byte counter increments.
  - After the 4th byte: if item == 32+TAM_DATA_MEMORY, the counter clears and the state goes to IDLE; otherwise the item increments and the state goes to LOAD.
- **Dump size:** 4·(33+TAM_DATA_MEMORY) bytes, which is 196 with the defaults.
- **TX handshake:**
  - `o_tx_data` is stable while `o_tx_valid` is high and `i_tx_ready` is low.
  - `o_tx_valid` is never high outside SEND.
- **Commands while busy:** not accepted, since ready is low. Upstream holds them.
- **Reset:** asynchronous and immediate, including in the middle of RUN or SEND.
  - State goes to IDLE; item, byte counter and shift register are cleared.
  - Output values in reset: `o_mips_step`=0, `o_tx_valid`=0, `o_tx_data`=0, both debug outputs =0, `o_busy`=0, `o_cmd_ready`=1.
  - A partial dump is abandoned and not resumed.

## Timing
- Command accepted at edge t0.
- 'S': STEP occupies t0–t1 (`o_mips_step` high). LOAD occupies t1–t2. The first byte is valid from t2.
- 'R': LOAD occupies t0–t1. The first byte is valid from t1.
- 'C': `o_mips_step` is high from t0 until the edge that samples halt. Step count = number of RUN cycles, which includes the cycle in which halt is high.
- With `i_tx_ready` held at 1, each item takes 5 cycles (1 LOAD + 4 SEND). A full default dump takes 245 cycles.
- `o_cmd_ready` rises in the cycle after the last byte's handshake.

## Test plan
- **Reset:** assert `i_reset` asynchronously between edges → all outputs are 0 and `o_cmd_ready`=1 immediately. After release, the controller is idle with no TX activity.
- **'S' step:** `i_tx_ready`=1, PC=0x0000001C → `o_mips_step` is high for exactly 1 cycle. Bytes 0–3 are 00 00 00 1C; byte counts are exact (196 bytes total); `o_cmd_ready` returns 245 cycles after STEP ends.
- **'C' run:** halt raised during the 10th RUN cycle → exactly 10 step cycles, then a dump follows.
- **'C' with halt already high:** 'C' sent while halt is high → zero step cycles, dump only.
- **Backpressure:**
  - `i_tx_ready` alternates 1,0 → each byte is held stable while not accepted; the byte sequence is identical to the no-stall run.
  - Register 5 = 0xDEADBEEF → bytes 24–27 are DE AD BE EF.
  - Memory word 2 = 0x12345678 → `o_debug_address`=8 while that item is loaded; bytes 140–143 are 12 34 56 78.
- **Invalid and busy commands:** 0x41 is consumed with no effect. A 'S' offered during SEND is not accepted until IDLE.
- **Reset mid-dump:** assert `i_reset` at byte 50 → TX stops at once. A following 'R' restarts the dump from PC byte 0.
